// File: rtl/tm_pkg.sv
// Shared types and constants for the Tsetlin-machine clause stages.
// Holds the controller state encoding, LFSR taps and the training pass length.
package tm_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        INF_RUN = 3'd1,
        INF_CAP = 3'd2,
        TRN_RUN = 3'd3,
        TRN_REL = 3'd4,
        DONE    = 3'd5
    } ctrl_state_t;

    // x^16 + x^14 + x^13 + x^11 + 1, shift-left Fibonacci form: bits 15,13,12,10.
    localparam logic [15:0] LFSR16_TAPS  = 16'hB400;
    localparam logic [7:0]  P_THRESH_DEF = 8'd64;
    localparam logic [1:0]  TRN_CYCLES   = 2'd3;

    function automatic logic lfsr_feedback(input logic [15:0] state, input logic [15:0] taps);
        return ^(state & taps);
    endfunction

endpackage

// File: rtl/clause_ctrl_if.sv
// Lane bus between the clause sequencer and its N_LIT Tsetlin automata.
// The controller is the master; the TA lanes are the slave side.
interface clause_ctrl_if #(
    parameter int N_LIT = 8
);
    logic [N_LIT-1:0] ta_ready;
    logic [N_LIT-1:0] ta_done;
    logic [N_LIT-1:0] ta_result;
    logic             ta_enable;
    logic             ta_training_sel;
    logic [N_LIT-1:0] ta_literal;
    logic             ta_type_feedback;
    logic             ta_clause_result;
    logic [N_LIT-1:0] ta_rand;
    logic             ta_rand_clk;

    modport master (
        input  ta_ready, ta_done, ta_result,
        output ta_enable, ta_training_sel, ta_literal, ta_type_feedback,
               ta_clause_result, ta_rand, ta_rand_clk
    );

    modport slave (
        output ta_ready, ta_done, ta_result,
        input  ta_enable, ta_training_sel, ta_literal, ta_type_feedback,
               ta_clause_result, ta_rand, ta_rand_clk
    );
endinterface

// File: rtl/tm_lfsr.sv
// Free-running Fibonacci LFSR, shared by the clause stages as a random source.
// Steps every cycle out of reset; SEED must be nonzero.
module tm_lfsr
    import tm_pkg::*;
#(
    parameter int             W    = 16,
    parameter logic [W-1:0]   SEED = 16'hACE1
) (
    input  logic         clk,
    input  logic         rst_n,
    output logic [W-1:0] q
);

    localparam logic [W-1:0] TAPS = W'(LFSR16_TAPS);

    logic [W-1:0] q_q;
    logic [W-1:0] q_d;

    // Next LFSR state: shift left, feedback enters at bit 0.
    always_comb begin
        q_d = {q_q[W-2:0], lfsr_feedback(16'(q_q), 16'(TAPS))};
    end

    // LFSR state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_q <= SEED;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/clause_ctrl.sv
// Clause sequencer: latches literals, runs one inference pass over the TA lanes,
// ANDs their results into the clause output, then optionally runs one training pass.
module clause_ctrl
    import tm_pkg::*;
#(
    parameter int                N_LIT    = 8,
    parameter int                LFSR_W   = 16,
    parameter logic [LFSR_W-1:0] SEED     = 16'hACE1,
    parameter logic [7:0]        P_THRESH = P_THRESH_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             train,
    input  logic             fb_type,
    input  logic [N_LIT-1:0] literals,
    clause_ctrl_if.master    lane,
    output logic             busy,
    output logic             valid,
    output logic             clause_out,
    output logic             err
);

    ctrl_state_t      state_q, state_d;
    logic [1:0]       cnt_q, cnt_d;
    logic [N_LIT-1:0] lit_q, lit_d;
    logic [N_LIT-1:0] rand_q, rand_d;
    logic             train_q, train_d;
    logic             fb_q, fb_d;
    logic             cres_q, cres_d;
    logic             en_q, en_d;
    logic             tsel_q, tsel_d;
    logic             rand_clk_q, rand_clk_d;
    logic             busy_q, busy_d;
    logic             valid_q, valid_d;
    logic             cout_q, cout_d;
    logic             err_q, err_d;

    logic [LFSR_W-1:0] lfsr_s;
    logic [N_LIT-1:0]  rand_s;
    logic              unused_s;

    tm_lfsr #(
        .W    (LFSR_W),
        .SEED (SEED)
    ) u_lfsr (
        .clk   (clk),
        .rst_n (rst_n),
        .q     (lfsr_s)
    );

    assign unused_s = ^lfsr_s;

    // Per-lane random bit: lane i looks at an 8-bit window starting at bit i.
    always_comb begin
        rand_s = {N_LIT{1'b0}};
        for (int i = 0; i < N_LIT; i++) begin
            rand_s[i] = (lfsr_s[i +: 8] < P_THRESH);
        end
    end

    // Sequencer next state; every output is computed here and registered below.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        lit_d      = lit_q;
        train_d    = train_q;
        fb_d       = fb_q;
        cres_d     = cres_q;
        rand_d     = rand_q;
        cout_d     = cout_q;
        err_d      = err_q;
        en_d       = 1'b0;
        tsel_d     = 1'b0;
        rand_clk_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (start && (&lane.ta_ready)) begin
                    lit_d   = literals;
                    train_d = train;
                    fb_d    = fb_type;
                    err_d   = 1'b0;
                    en_d    = 1'b1;
                    state_d = INF_RUN;
                end else begin
                    state_d = IDLE;
                end
            end
            INF_RUN: begin
                state_d = INF_CAP;
            end
            INF_CAP: begin
                if (&lane.ta_done) begin
                    cout_d = &lane.ta_result;
                    cres_d = &lane.ta_result;
                    if (train_q) begin
                        state_d    = TRN_RUN;
                        cnt_d      = TRN_CYCLES - 2'd1;
                        en_d       = 1'b1;
                        tsel_d     = 1'b1;
                        rand_d     = rand_s;
                        rand_clk_d = 1'b1;
                    end else begin
                        state_d = DONE;
                    end
                end else begin
                    // A lane missed its handshake: report it and skip training.
                    err_d   = 1'b1;
                    cout_d  = 1'b0;
                    state_d = DONE;
                end
            end
            TRN_RUN: begin
                if (cnt_q == 2'd0) begin
                    state_d = TRN_REL;
                end else begin
                    cnt_d  = cnt_q - 2'd1;
                    en_d   = 1'b1;
                    tsel_d = 1'b1;
                end
            end
            TRN_REL: begin
                state_d = DONE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        valid_d = (state_d == DONE);
        busy_d  = (state_d != IDLE);
    end

    // Sequencer state and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= 2'd0;
            lit_q      <= {N_LIT{1'b0}};
            train_q    <= 1'b0;
            fb_q       <= 1'b0;
            cres_q     <= 1'b0;
            rand_q     <= {N_LIT{1'b0}};
            cout_q     <= 1'b0;
            err_q      <= 1'b0;
            en_q       <= 1'b0;
            tsel_q     <= 1'b0;
            rand_clk_q <= 1'b0;
            busy_q     <= 1'b0;
            valid_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            lit_q      <= lit_d;
            train_q    <= train_d;
            fb_q       <= fb_d;
            cres_q     <= cres_d;
            rand_q     <= rand_d;
            cout_q     <= cout_d;
            err_q      <= err_d;
            en_q       <= en_d;
            tsel_q     <= tsel_d;
            rand_clk_q <= rand_clk_d;
            busy_q     <= busy_d;
            valid_q    <= valid_d;
        end
    end

    assign lane.ta_enable        = en_q;
    assign lane.ta_training_sel  = tsel_q;
    assign lane.ta_literal       = lit_q;
    assign lane.ta_type_feedback = fb_q;
    assign lane.ta_clause_result = cres_q;
    assign lane.ta_rand          = rand_q;
    assign lane.ta_rand_clk      = rand_clk_q;
    assign busy                  = busy_q;
    assign valid                 = valid_q;
    assign clause_out            = cout_q;
    assign err                   = err_q;

endmodule

// File: tb/tb_clause_ctrl.sv
// Scoreboard bench for clause_ctrl: eight behavioural TA lanes, random transactions,
// and a second instance with P_THRESH=0 whose random bits must stay zero.
module tb_clause_ctrl;

    localparam int          N      = 8;
    localparam logic [15:0] SEED   = 16'hACE1;
    localparam int          THRESH = 64;

    typedef struct {
        logic         cout;
        logic         err;
        logic         cres;
        int           lat;
        logic [N-1:0] lit;
        logic         fb;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic         train = 1'b0;
    logic         fb_type = 1'b0;
    logic [N-1:0] literals = '0;
    logic         busy, valid, clause_out, err;
    logic         busy0, valid0, cout0, err0;

    clause_ctrl_if #(.N_LIT(N)) lif ();
    clause_ctrl_if #(.N_LIT(N)) zif ();

    clause_ctrl #(.N_LIT(N), .LFSR_W(16), .SEED(SEED), .P_THRESH(8'd64)) u_dut (
        .clk(clk), .rst_n(rst_n), .start(start), .train(train), .fb_type(fb_type),
        .literals(literals), .lane(lif), .busy(busy), .valid(valid),
        .clause_out(clause_out), .err(err)
    );

    clause_ctrl #(.N_LIT(N), .LFSR_W(16), .SEED(SEED), .P_THRESH(8'd0)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .start(start), .train(train), .fb_type(fb_type),
        .literals(literals), .lane(zif), .busy(busy0), .valid(valid0),
        .clause_out(cout0), .err(err0)
    );

    always #5 clk = ~clk;

    assign zif.ta_ready  = '1;
    assign zif.ta_done   = '1;
    assign zif.ta_result = '1;

    // ---------------- behavioural TA lanes ----------------
    // lane states: 0 INFERENCE, 1 OUT, 2 TRAIN, 3 FEEDBACK, 4 waiting for release
    int           st[N];
    logic [1:0]   wt[N];
    logic [N-1:0] res_r;
    logic         kill3 = 1'b0;
    logic [N-1:0] ready_mask = '1;
    logic [N-1:0] rdy_v, done_v, done_raw;

    function automatic logic [1:0] upd(input logic [1:0] w, input logic lit, input logic cr,
                                       input logic fb, input logic rnd);
        if (!fb) begin
            if (cr && lit) return (w == 2'd3) ? w : w + 2'd1;
            else if (rnd) return (w == 2'd0) ? w : w - 2'd1;
            else return w;
        end else begin
            if (cr && !lit && w < 2'd2) return w + 2'd1;
            else return w;
        end
    endfunction

    always_comb begin
        rdy_v = '0;
        done_v = '0;
        done_raw = '0;
        for (int i = 0; i < N; i++) begin
            done_raw[i] = (st[i] == 1);
            rdy_v[i]    = (st[i] == 0) && ready_mask[i];
            done_v[i]   = done_raw[i] && !(kill3 && i == 3);
        end
    end

    assign lif.ta_ready  = rdy_v;
    assign lif.ta_done   = done_v;
    assign lif.ta_result = res_r;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N; i++) begin
                st[i] <= 0;
                wt[i] <= 2'd2;
            end
            res_r <= '0;
        end else begin
            for (int i = 0; i < N; i++) begin
                case (st[i])
                    0: begin
                        if (lif.ta_enable && !lif.ta_training_sel) begin
                            st[i]    <= 1;
                            res_r[i] <= (wt[i] >= 2'd2) ? lif.ta_literal[i] : 1'b1;
                        end else if (lif.ta_enable) begin
                            st[i] <= 2;
                        end
                    end
                    1: if (!lif.ta_enable) st[i] <= 0;
                    2: st[i] <= lif.ta_enable ? 3 : 0;
                    3: begin
                        if (lif.ta_enable) begin
                            st[i] <= 4;
                            wt[i] <= upd(wt[i], lif.ta_literal[i], lif.ta_clause_result,
                                         lif.ta_type_feedback, lif.ta_rand[i]);
                        end else begin
                            st[i] <= 0;
                        end
                    end
                    default: if (!lif.ta_enable) st[i] <= 0;
                endcase
            end
        end
    end

    // ---------------- reference random source ----------------
    logic [15:0] mlfsr;
    logic [15:0] lfsr_prev = 16'h0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) mlfsr <= SEED;
        else        mlfsr <= {mlfsr[14:0], mlfsr[15] ^ mlfsr[13] ^ mlfsr[12] ^ mlfsr[10]};
    end

    function automatic logic [N-1:0] exp_rand(input logic [15:0] v, input int th);
        logic [N-1:0] r;
        for (int i = 0; i < N; i++) r[i] = ((int'(v >> i) & 255) < th);
        return r;
    endfunction

    // ---------------- checking ----------------
    int   n_chk = 0;
    int   n_pass = 0;
    int   cyc = 0;
    int   acc_cyc = -100;
    int   cur_lat = 0;
    logic cur_trn = 1'b0;
    logic exp_err_now = 1'b0;
    logic last_cres = 1'b0;
    exp_t sbq[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] ex);
        n_chk++;
        if (act === ex) n_pass++;
        else $display("FAIL %s: actual=%0h required=%0h", nm, act, ex);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_valid"}, valid, 0);
        chk({tag, "_clause_out"}, clause_out, 0);
        chk({tag, "_err"}, err, 0);
        chk({tag, "_enable"}, lif.ta_enable, 0);
        chk({tag, "_training_sel"}, lif.ta_training_sel, 0);
        chk({tag, "_literal"}, lif.ta_literal, 0);
        chk({tag, "_type_fb"}, lif.ta_type_feedback, 0);
        chk({tag, "_clause_result"}, lif.ta_clause_result, 0);
        chk({tag, "_rand"}, lif.ta_rand, 0);
        chk({tag, "_rand_clk"}, lif.ta_rand_clk, 0);
    endtask

    // Monitor: per-cycle control pattern plus scoreboard pop on every valid.
    always @(negedge clk) begin
        int   k;
        logic tw;
        exp_t e;
        if (rst_n) begin
            k  = cyc - acc_cyc + 1;
            tw = cur_trn && (k >= 3) && (k <= 5);
            if (k >= 1 && k <= cur_lat) begin
                chk("ta_enable", lif.ta_enable, (k == 1) || tw);
                chk("training_sel", lif.ta_training_sel, tw);
                chk("rand_clk", lif.ta_rand_clk, cur_trn && (k == 3));
                chk("busy", busy, 1);
            end else begin
                chk("busy_idle", busy, 0);
            end
            if (lif.ta_enable) chk("enable_over_out", done_raw, 0);
            if (lif.ta_rand_clk) chk("ta_rand", lif.ta_rand, exp_rand(lfsr_prev, THRESH));
            if (zif.ta_rand_clk) chk("ta_rand_pthresh0", zif.ta_rand, 0);
            if (valid0) begin
                chk("p0_clause_out", cout0, 1);
                chk("p0_err", err0, 0);
            end
            if (valid) begin
                if (sbq.size() == 0) begin
                    chk("unexpected_valid", valid, 0);
                end else begin
                    e = sbq.pop_front();
                    chk("clause_out", clause_out, e.cout);
                    chk("err", err, e.err);
                    chk("ta_clause_result", lif.ta_clause_result, e.cres);
                    chk("latency", k, e.lat);
                    chk("ta_literal", lif.ta_literal, e.lit);
                    chk("ta_type_feedback", lif.ta_type_feedback, e.fb);
                    chk("ready_at_valid", rdy_v, 32'hFF);
                end
            end
            lfsr_prev <= mlfsr;
        end
    end

    // ---------------- stimulus ----------------
    task automatic wait_idle();
        int guard = 0;
        while (((cyc - acc_cyc + 1) <= cur_lat) || (rdy_v != {N{1'b1}})) begin
            @(negedge clk);
            guard++;
            if (guard > 100) begin
                n_chk++;
                $display("FAIL idle_timeout: actual=busy required=idle");
                cur_lat = 0;
                break;
            end
        end
        @(negedge clk);
    endtask

    task automatic do_txn(input logic [N-1:0] lit, input logic tr, input logic fb,
                          input logic kill, input logic hold);
        exp_t e;
        logic all1;
        wait_idle();
        chk("err_sticky", err, exp_err_now);
        literals = lit;
        train    = tr;
        fb_type  = fb;
        kill3    = kill;
        start    = 1'b1;
        all1 = 1'b1;
        for (int i = 0; i < N; i++) if (wt[i] >= 2'd2 && !lit[i]) all1 = 1'b0;
        e.cout = kill ? 1'b0 : all1;
        e.err  = kill;
        e.cres = kill ? last_cres : all1;
        e.lat  = (tr && !kill) ? 7 : 3;
        e.lit  = lit;
        e.fb   = fb;
        last_cres   = e.cres;
        exp_err_now = kill;
        @(posedge clk);
        #1;
        acc_cyc = cyc;
        cur_trn = tr && !kill;
        cur_lat = e.lat;
        sbq.push_back(e);
        start = 1'b0;
        if (hold) begin
            @(negedge clk);
            start    = 1'b1;
            literals = ~lit;
            train    = ~tr;
            fb_type  = ~fb;
            @(negedge clk);
            @(negedge clk);
            start = 1'b0;
        end
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst_n = 1'b1;

        do_txn(8'hFF, 1'b0, 1'b0, 1'b0, 1'b0);
        do_txn(8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        do_txn(8'hFF, 1'b1, 1'b1, 1'b0, 1'b0);
        do_txn(8'h5A, 1'b1, 1'b0, 1'b1, 1'b0);
        do_txn(8'hA5, 1'b0, 1'b0, 1'b0, 1'b0);
        do_txn(8'h3C, 1'b1, 1'b0, 1'b0, 1'b1);

        // start with one lane not ready must be ignored
        wait_idle();
        ready_mask = 8'hFE;
        start = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("busy_not_ready", busy, 0);
        end
        start = 1'b0;
        ready_mask = '1;

        for (int n = 0; n < 40; n++) begin
            do_txn(N'($urandom), 1'($urandom), 1'($urandom),
                   ($urandom_range(0, 7) == 0), ($urandom_range(0, 3) == 0));
        end

        // reset in the middle of the training pass
        do_txn(8'hFF, 1'b1, 1'b0, 1'b0, 1'b0);
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_all_zero("midreset");
        sbq.delete();
        cur_lat     = 0;
        last_cres   = 1'b0;
        exp_err_now = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        do_txn(8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        do_txn(8'hF0, 1'b1, 1'b0, 1'b0, 1'b0);
        do_txn(8'h0F, 1'b1, 1'b1, 1'b0, 1'b0);
        wait_idle();
        repeat (2) @(negedge clk);
        chk("scoreboard_drained", sbq.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
